// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_SRC writeback sources.
// Optional WB_ARB_PERF_EN adds a saturating contention counter (conflict_cnt_o).
module wb_port_arbiter #(
  parameter  int NUM_SRC = 3,
  parameter  int XLEN    = 64,
  localparam int PTR_W   = $clog2(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [NUM_SRC-1:0]      req_valid_i,
  output logic [NUM_SRC-1:0]      req_ready_o,
  input  logic [NUM_SRC*5-1:0]    req_rd_addr_i,
  input  logic [NUM_SRC*XLEN-1:0] req_rd_data_i,
  output logic                    rd_wen_o,
  output logic [4:0]              rd_addr_o,
  output logic [XLEN-1:0]         rd_data_o
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]             conflict_cnt_o
`endif
);

  logic [NUM_SRC-1:0][4:0]      w_addr;
  logic [NUM_SRC-1:0][XLEN-1:0] w_data;
  logic [PTR_W-1:0]             r_rr_ptr;
  logic [PTR_W-1:0]             w_gnt_idx;
  logic [PTR_W-1:0]             w_ptr_nxt;
  logic                         w_found;
  logic                         w_xfer;
  logic                         r_wen;
  logic [4:0]                   r_addr;
  logic [XLEN-1:0]              r_data;

  assign w_addr = req_rd_addr_i;
  assign w_data = req_rd_data_i;

  // Search from the pointer upward with wrap; first valid source wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_SRC);
      if (!w_found && req_valid_i[idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  // Ready is forced low during reset so no source sees a phantom grant.
  assign w_xfer      = w_found && !flush_i && rst_n;
  assign req_ready_o = w_xfer ? (NUM_SRC'(1) << w_gnt_idx) : '0;
  assign w_ptr_nxt   = (w_gnt_idx == PTR_W'(NUM_SRC-1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_rr_ptr <= '0;
    end else begin
      // x0 writes are consumed but never reach the register file.
      r_wen <= w_xfer && (w_addr[w_gnt_idx] != 5'd0);
      if (w_xfer) begin
        r_addr   <= w_addr[w_gnt_idx];
        r_data   <= w_data[w_gnt_idx];
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign rd_wen_o  = r_wen;
  assign rd_addr_o = r_addr;
  assign rd_data_o = r_data;

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_conflict_cnt <= '0;
    else if (!flush_i && ($countones(req_valid_i) >= 2) && (r_conflict_cnt != 32'hFFFF_FFFF))
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
  end

  assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single grant, round-robin contention,
// x0 drop, flush, stall hold and reset mid-transfer, with hand-computed expectations.
module tb_wb_port_arbiter;

  localparam int NS = 3;
  localparam int XL = 64;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [NS-1:0]     valid;
  logic [NS-1:0]     ready;
  logic [NS*5-1:0]   addr_bus;
  logic [NS*XL-1:0]  data_bus;
  logic              wen;
  logic [4:0]        waddr;
  logic [XL-1:0]     wdata;
`ifdef WB_ARB_PERF_EN
  logic [31:0]       ccnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  wb_port_arbiter #(.NUM_SRC(NS), .XLEN(XL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .req_valid_i   (valid),
    .req_ready_o   (ready),
    .req_rd_addr_i (addr_bus),
    .req_rd_data_i (data_bus),
    .rd_wen_o      (wen),
    .rd_addr_o     (waddr),
    .rd_data_o     (wdata)
`ifdef WB_ARB_PERF_EN
    ,
    .conflict_cnt_o(ccnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] a, input logic [63:0] d);
    addr_bus[5*i +: 5]   = a;
    data_bus[XL*i +: XL] = d;
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    valid    = 3'b111;
    addr_bus = '0;
    data_bus = '0;

    // Reset state
    #3;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_wen",   64'(wen),   64'd0);
    chk("rst_addr",  64'(waddr), 64'd0);
    chk("rst_data",  wdata,      64'd0);
    step();
    step();
    rst_n = 1'b1;
    valid = 3'b000;

    // Contention from ptr=0: grants 0,1,2,0,1,2 with no bubbles
    set_src(0, 5'd1, 64'hA0);
    set_src(1, 5'd2, 64'hA1);
    set_src(2, 5'd3, 64'hA2);
    valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_ready", 64'(ready), 64'(3'b001 << (c % 3)));
      step();
      chk("rr_wen",  64'(wen),   64'd1);
      chk("rr_addr", 64'(waddr), 64'((c % 3) + 1));
      chk("rr_data", wdata,      64'hA0 + 64'(c % 3));
    end
`ifdef WB_ARB_PERF_EN
    chk("perf_cnt", 64'(ccnt), 64'd6);
`endif
    valid = 3'b000;
    step();
    chk("idle_wen",  64'(wen),   64'd0);
    chk("idle_addr", 64'(waddr), 64'd3);

    // Single source: src1, addr 5, DEAD_BEEF (ptr=0)
    set_src(1, 5'd5, 64'hDEAD_BEEF);
    valid = 3'b010;
    #1;
    chk("single_ready", 64'(ready), 64'b010);
    step();
    valid = 3'b000;
    chk("single_wen",  64'(wen),   64'd1);
    chk("single_addr", 64'(waddr), 64'd5);
    chk("single_data", wdata,      64'hDEAD_BEEF);
    step();
    // ptr=2: grant src2 once to bring ptr back to 0
    set_src(2, 5'd3, 64'h33);
    valid = 3'b100;
    #1;
    chk("wrap_ready", 64'(ready), 64'b100);
    step();
    valid = 3'b000;
    step();

    // x0 drop: accepted, no write, ptr advances to 1
    set_src(0, 5'd0, 64'h55);
    valid = 3'b001;
    #1;
    chk("x0_ready", 64'(ready), 64'b001);
    step();
    valid = 3'b000;
    chk("x0_wen",  64'(wen),   64'd0);
    chk("x0_addr", 64'(waddr), 64'd0);
    chk("x0_data", wdata,      64'h55);
    set_src(0, 5'd6, 64'h66);
    set_src(1, 5'd7, 64'h77);
    valid = 3'b011;
    #1;
    chk("x0_ptr1", 64'(ready), 64'b010);
    step();
    valid = 3'b000;
    chk("x0_next_addr", 64'(waddr), 64'd7);
    step();

    // Flush with ptr=2: src0 and src2 valid, no grants for 2 cycles, ptr held
    set_src(2, 5'd9, 64'h99);
    valid = 3'b101;
    flush = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("fl_ready", 64'(ready), 64'd0);
      step();
      chk("fl_wen", 64'(wen), 64'd0);
    end
    flush = 1'b0;
    #1;
    chk("fl_after_ready", 64'(ready), 64'b100);
    step();
    valid = 3'b001;
    flush = 1'b1;
    #1;
    chk("fl_inflight_wen",  64'(wen),   64'd1);
    chk("fl_inflight_addr", 64'(waddr), 64'd9);
    chk("fl_inflight_rdy",  64'(ready), 64'd0);
    step();
    chk("fl_wen2", 64'(wen), 64'd0);
    flush = 1'b0;
    #1;
    chk("fl_src0_ready", 64'(ready), 64'b001);
    step();
    valid = 3'b000;
    chk("fl_src0_addr", 64'(waddr), 64'd6);
    step();

    // ptr=1: grant src2 then src... bring ptr to 0 via src2
    valid = 3'b100;
    step();
    valid = 3'b000;
    step();

    // Stall hold: src0 and src1 valid from ptr=0, src1 held until granted
    set_src(0, 5'd10, 64'h1010);
    set_src(1, 5'd11, 64'h1111);
    valid = 3'b011;
    #1;
    chk("st_ready0", 64'(ready), 64'b001);
    step();
    valid = 3'b010;
    chk("st_addr0", 64'(waddr), 64'd10);
    #1;
    chk("st_ready1", 64'(ready), 64'b010);
    step();
    valid = 3'b000;
    chk("st_wen1",  64'(wen),   64'd1);
    chk("st_addr1", 64'(waddr), 64'd11);
    chk("st_data1", wdata,      64'h1111);
    step();

    // Reset mid-transfer: write registered, then async reset clears it
    set_src(0, 5'd4, 64'h44);
    valid = 3'b001;
    step();
    valid = 3'b111;
    chk("mr_pre_wen", 64'(wen), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_wen",   64'(wen),   64'd0);
    chk("mr_ready", 64'(ready), 64'd0);
    chk("mr_addr",  64'(waddr), 64'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mr_first_grant", 64'(ready), 64'b001);
    step();
    valid = 3'b000;
    chk("mr_first_addr", 64'(waddr), 64'd4);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
